// File: rtl/lv_rac_pkg.sv
`default_nettype none
//=============================================================================
// Module      : lv_rac_pkg
// Description : Shared widths, CRC polynomial and enums for the LV register
//               access controller.
// Revision    : 1.0 - initial release
//=============================================================================
package lv_rac_pkg;

   localparam int         LV_REG_AW    = 7;
   localparam int         LV_REG_DW    = 8;
   localparam int         LV_REG_CRC_W = 8;
   localparam logic [7:0] LV_CRC_POLY  = 8'h07;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      CAPT   = 2'd2,
      ACK    = 2'd3
   } rac_state_e;

   typedef enum logic {
      SRC_HOST = 1'b0,
      SRC_WDG  = 1'b1
   } rac_src_e;

endpackage
`default_nettype wire

// File: rtl/crc16to8_parallel.sv
`default_nettype none
//=============================================================================
// Module      : crc16to8_parallel
// Description : Single-cycle MSB-first CRC (init 0, no reflection) of a word.
// Revision    : 1.0 - initial release
//=============================================================================
module crc16to8_parallel #(
   parameter int               IN_W  = 16,
   parameter int               OUT_W = 8,
   parameter logic [OUT_W-1:0] POLY  = 8'h07
) (
   input  logic [IN_W-1:0]  i_data,
   output logic [OUT_W-1:0] o_crc
);

   logic [OUT_W-1:0] w_crc;

   // Bit-serial LFSR unrolled into one combinational cone.
   always_comb begin
      w_crc = '0;
      for (int i = IN_W - 1; i >= 0; i--) begin
         if (w_crc[OUT_W-1] ^ i_data[i]) begin
            w_crc = {w_crc[OUT_W-2:0], 1'b0} ^ POLY;
         end else begin
            w_crc = {w_crc[OUT_W-2:0], 1'b0};
         end
      end
   end

   assign o_crc = w_crc;

endmodule
`default_nettype wire

// File: rtl/lv_reg_access_ctrl.sv
`default_nettype none
//=============================================================================
// Module      : lv_reg_access_ctrl
// Description : Arbitrates host and watchdog-scan requests onto the LV register
//               bank, one access at a time, returning read data with a CRC.
//               Optional host write protection: define LV_RAC_WR_PROT_EN.
// Revision    : 1.0 - initial release
//=============================================================================
module lv_reg_access_ctrl
   import lv_rac_pkg::*;
#(
   parameter int                REG_AW         = LV_REG_AW,
   parameter int                REG_DW         = LV_REG_DW,
   parameter int                REG_CRC_W      = LV_REG_CRC_W,
   parameter logic [REG_AW-1:0] LOCK_BASE_ADDR = 7'h40
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_host_req,
   input  logic                 i_host_wr,
   input  logic [REG_AW-1:0]    i_host_addr,
   input  logic [REG_DW-1:0]    i_host_wdata,
   output logic                 o_host_ack,
   output logic [REG_DW-1:0]    o_host_rdata,
   output logic [REG_CRC_W-1:0] o_host_crc,
   output logic                 o_host_wr_err,
   input  logic                 i_wdg_scan_rac_rd_req,
   input  logic [REG_AW-1:0]    i_wdg_scan_rac_addr,
   output logic                 o_rac_wdg_scan_ack,
   output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
   output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
   input  logic                 i_reg_lock,
   output logic                 o_reg_rd_en,
   output logic                 o_reg_wr_en,
   output logic [REG_AW-1:0]    o_reg_addr,
   output logic [REG_DW-1:0]    o_reg_wdata,
   input  logic [REG_DW-1:0]    i_reg_rdata
);

   generate
      if (REG_AW + REG_DW + 1 != 16) begin : g_width_chk
         $error("lv_reg_access_ctrl: REG_AW + REG_DW + 1 must equal 16");
      end
   endgenerate

   rac_state_e           r_state;
   rac_src_e             r_src;
   rac_src_e             r_last_grant;
   logic                 r_wr;
   rac_src_e             w_grant;
   logic                 w_grant_valid;
   logic                 w_grant_wr;
   logic                 w_blocked;
   logic [REG_CRC_W-1:0] w_crc;

   // On a collision the source that did not win last time gets the bank.
   always_comb begin
      w_grant_valid = i_host_req | i_wdg_scan_rac_rd_req;
      w_grant       = SRC_WDG;
      if (i_host_req && i_wdg_scan_rac_rd_req) begin
         w_grant = (r_last_grant == SRC_WDG) ? SRC_HOST : SRC_WDG;
      end else if (i_host_req) begin
         w_grant = SRC_HOST;
      end
      w_grant_wr = (w_grant == SRC_HOST) && i_host_wr;
   end

   crc16to8_parallel #(
      .IN_W  (REG_AW + REG_DW + 1),
      .OUT_W (REG_CRC_W),
      .POLY  (LV_CRC_POLY)
   ) u_crc (
      .i_data ({r_src == SRC_WDG, o_reg_addr, i_reg_rdata}),
      .o_crc  (w_crc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state             <= IDLE;
         r_src               <= SRC_HOST;
         r_last_grant        <= SRC_WDG;
         r_wr                <= 1'b0;
         o_host_ack          <= 1'b0;
         o_host_rdata        <= '0;
         o_host_crc          <= '0;
         o_rac_wdg_scan_ack  <= 1'b0;
         o_rac_wdg_scan_data <= '0;
         o_rac_wdg_scan_crc  <= '0;
         o_reg_rd_en         <= 1'b0;
         o_reg_wr_en         <= 1'b0;
         o_reg_addr          <= '0;
         o_reg_wdata         <= '0;
      end else begin
         o_host_ack         <= 1'b0;
         o_rac_wdg_scan_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_state      <= ACCESS;
                  r_src        <= w_grant;
                  r_last_grant <= w_grant;
                  r_wr         <= w_grant_wr;
                  o_reg_rd_en  <= !w_grant_wr;
                  o_reg_wr_en  <= w_grant_wr && !w_blocked;
                  if (w_grant == SRC_HOST) begin
                     o_reg_addr  <= i_host_addr;
                     o_reg_wdata <= i_host_wdata;
                  end else begin
                     o_reg_addr  <= i_wdg_scan_rac_addr;
                  end
               end
            end
            ACCESS: begin
               o_reg_rd_en <= 1'b0;
               o_reg_wr_en <= 1'b0;
               if (r_wr) begin
                  r_state    <= ACK;
                  o_host_ack <= 1'b1;
               end else begin
                  r_state    <= CAPT;
               end
            end
            CAPT: begin
               r_state <= ACK;
               if (r_src == SRC_WDG) begin
                  o_rac_wdg_scan_data <= i_reg_rdata;
                  o_rac_wdg_scan_crc  <= w_crc;
                  o_rac_wdg_scan_ack  <= 1'b1;
               end else begin
                  o_host_rdata <= i_reg_rdata;
                  o_host_crc   <= w_crc;
                  o_host_ack   <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef LV_RAC_WR_PROT_EN
   logic r_blocked;

   assign w_blocked = i_reg_lock && (i_host_addr >= LOCK_BASE_ADDR);

   // Blocked writes still walk ACCESS -> ACK; the error rides on the ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_blocked     <= 1'b0;
         o_host_wr_err <= 1'b0;
      end else begin
         o_host_wr_err <= 1'b0;
         if (r_state == IDLE && w_grant_valid) begin
            r_blocked <= w_grant_wr && w_blocked;
         end
         if (r_state == ACCESS && r_wr) begin
            o_host_wr_err <= r_blocked;
         end
      end
   end
`else
   logic w_unused_prot;

   assign w_blocked     = 1'b0;
   assign o_host_wr_err = 1'b0;
   assign w_unused_prot = ^{i_reg_lock, LOCK_BASE_ADDR};
`endif

endmodule
`default_nettype wire

// File: tb/tb_lv_reg_access_ctrl.sv
`default_nettype none
//=============================================================================
// Module      : tb_lv_reg_access_ctrl
// Description : Self-checking bench for lv_reg_access_ctrl: vector table,
//               directed corner sequences and a randomized model check.
// Revision    : 1.0 - initial release
//=============================================================================
module tb_lv_reg_access_ctrl;

`ifdef LV_RAC_WR_PROT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_host_req = 1'b0, i_host_wr = 1'b0;
   logic [6:0] i_host_addr = '0;
   logic [7:0] i_host_wdata = '0;
   logic       o_host_ack, o_host_wr_err, o_rac_wdg_scan_ack;
   logic [7:0] o_host_rdata, o_host_crc, o_rac_wdg_scan_data, o_rac_wdg_scan_crc;
   logic       i_wdg_scan_rac_rd_req = 1'b0;
   logic [6:0] i_wdg_scan_rac_addr = '0;
   logic       i_reg_lock = 1'b0;
   logic       o_reg_rd_en, o_reg_wr_en;
   logic [6:0] o_reg_addr;
   logic [7:0] o_reg_wdata;
   logic [7:0] i_reg_rdata;

   lv_reg_access_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_host_req(i_host_req), .i_host_wr(i_host_wr), .i_host_addr(i_host_addr),
      .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
      .o_host_crc(o_host_crc), .o_host_wr_err(o_host_wr_err),
      .i_wdg_scan_rac_rd_req(i_wdg_scan_rac_rd_req), .i_wdg_scan_rac_addr(i_wdg_scan_rac_addr),
      .o_rac_wdg_scan_ack(o_rac_wdg_scan_ack), .o_rac_wdg_scan_data(o_rac_wdg_scan_data),
      .o_rac_wdg_scan_crc(o_rac_wdg_scan_crc), .i_reg_lock(i_reg_lock),
      .o_reg_rd_en(o_reg_rd_en), .o_reg_wr_en(o_reg_wr_en), .o_reg_addr(o_reg_addr),
      .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Register bank: data valid the cycle after rd_en, noise otherwise.
   logic [7:0] mem [128];
   always @(posedge i_clk) begin
      if (o_reg_wr_en) mem[o_reg_addr] <= o_reg_wdata;
      if (o_reg_rd_en) i_reg_rdata <= mem[o_reg_addr];
      else             i_reg_rdata <= 8'($urandom);
   end

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int h_ack, s_ack, err_at, rd_at, wr_at, n_h, n_s, n_rd, n_wr, n_err;
   logic [6:0] strobe_addr;
   logic [7:0] strobe_wdata;

   // Reference model state
   logic [7:0] ref_mem [128];
   bit         m_last_scan;
   logic [7:0] m_hrd, m_hcrc, m_sd, m_scrc;

   function automatic logic [7:0] crc_ref(input logic [15:0] w);
      logic [23:0] r;
      r = {w, 8'h00};
      for (int i = 23; i >= 8; i--)
         if (r[i]) r = r ^ (24'h107 << (i - 8));
      return r[7:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      m_last_scan = 1'b1;
      m_hrd = '0; m_hcrc = '0; m_sd = '0; m_scrc = '0;
   endtask

   task automatic drive(input bit h, input bit s, input bit hwr, input logic [6:0] haddr,
                        input logic [7:0] hwd, input logic [6:0] saddr);
      i_host_req = h; i_host_wr = hwr; i_host_addr = haddr; i_host_wdata = hwd;
      i_wdg_scan_rac_rd_req = s; i_wdg_scan_rac_addr = saddr;
   endtask

   // Fixed cycle budget; requesters drop their level as soon as ack is seen.
   task automatic run(input int n0, input int ncyc, input int drop_at);
      h_ack = -1; s_ack = -1; err_at = -1; rd_at = -1; wr_at = -1;
      n_h = 0; n_s = 0; n_rd = 0; n_wr = 0; n_err = 0;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         if (o_reg_rd_en) begin
            n_rd++;
            if (rd_at < 0) begin rd_at = cyc - n0; strobe_addr = o_reg_addr; end
         end
         if (o_reg_wr_en) begin
            n_wr++;
            if (wr_at < 0) begin
               wr_at = cyc - n0; strobe_addr = o_reg_addr; strobe_wdata = o_reg_wdata;
            end
         end
         if (o_host_ack) begin n_h++; if (h_ack < 0) h_ack = cyc - n0; i_host_req = 1'b0; end
         if (o_rac_wdg_scan_ack) begin
            n_s++; if (s_ack < 0) s_ack = cyc - n0; i_wdg_scan_rac_rd_req = 1'b0;
         end
         if (o_host_wr_err) begin n_err++; err_at = cyc - n0; end
         if (k == drop_at) i_wdg_scan_rac_rd_req = 1'b0;
      end
   endtask

   // Predicts service order, ack offsets and results, then compares.
   task automatic model_check(input bit h, input bit s, input bit hwr, input logic [6:0] haddr,
                              input logic [7:0] hwd, input logic [6:0] saddr);
      int ord [2];
      int no = 0, t = 0, eh = -1, es = -1, erd = 0, ewr = 0, eerr = 0;
      bit blk;
      blk = h && hwr && PROT && i_reg_lock && (haddr >= 7'h40);
      if (h && (!s || m_last_scan)) begin
         ord[no] = 0; no++;
         if (s) begin ord[no] = 1; no++; end
      end else begin
         if (s) begin ord[no] = 1; no++; end
         if (h) begin ord[no] = 0; no++; end
      end
      for (int j = 0; j < no; j++) begin
         if (ord[j] == 0) begin
            if (hwr) begin
               eh = t + 2;
               if (blk) eerr++;
               else begin ref_mem[haddr] = hwd; ewr++; end
            end else begin
               eh = t + 3; erd++;
               m_hrd = ref_mem[haddr]; m_hcrc = crc_ref({1'b0, haddr, m_hrd});
            end
            m_last_scan = 1'b0; t = eh + 1;
         end else begin
            es = t + 3; erd++;
            m_sd = ref_mem[saddr]; m_scrc = crc_ref({1'b1, saddr, m_sd});
            m_last_scan = 1'b1; t = es + 1;
         end
      end
      chk("host_ack_cyc", h_ack, eh);
      chk("scan_ack_cyc", s_ack, es);
      chk("host_ack_cnt", n_h, h ? 1 : 0);
      chk("scan_ack_cnt", n_s, s ? 1 : 0);
      chk("rd_en_cnt", n_rd, erd);
      chk("wr_en_cnt", n_wr, ewr);
      chk("wr_err_cyc", err_at, (eerr != 0) ? eh : -1);
      chk("host_rdata", o_host_rdata, m_hrd);
      chk("host_crc", o_host_crc, m_hcrc);
      chk("scan_data", o_rac_wdg_scan_data, m_sd);
      chk("scan_crc", o_rac_wdg_scan_crc, m_scrc);
      if (h && hwr) chk("bank_after_wr", mem[haddr], ref_mem[haddr]);
   endtask

   task automatic txn(input bit h, input bit s, input bit hwr, input logic [6:0] haddr,
                      input logic [7:0] hwd, input logic [6:0] saddr);
      int n0;
      n0 = cyc;
      drive(h, s, hwr, haddr, hwd, saddr);
      run(n0, 10, 0);
      model_check(h, s, hwr, haddr, hwd, saddr);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_hostside"}, {o_host_ack, o_host_rdata, o_host_crc, o_host_wr_err}, 64'd0);
      chk({tag, "_scanside"}, {o_rac_wdg_scan_ack, o_rac_wdg_scan_data, o_rac_wdg_scan_crc}, 64'd0);
      chk({tag, "_bankside"}, {o_reg_rd_en, o_reg_wr_en, o_reg_addr, o_reg_wdata}, 64'd0);
   endtask

   typedef struct {
      bit         scan;
      bit         wr;
      logic [6:0] addr;
      logic [7:0] data;      // preload for reads, write data for writes
      int         ack_off;
      int         strobe_off;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 7'h0B, 8'h5A, 3, 1};
      vecs[1] = '{1'b0, 1'b1, 7'h09, 8'hA5, 2, 1};
      vecs[2] = '{1'b0, 1'b0, 7'h7F, 8'hC3, 3, 1};
      vecs[3] = '{1'b1, 1'b0, 7'h00, 8'hFF, 3, 1};
      vecs[4] = '{1'b0, 1'b0, 7'h00, 8'h00, 3, 1};
      vecs[5] = '{1'b0, 1'b1, 7'h7F, 8'h3C, 2, 1};

      for (int i = 0; i < 128; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      model_reset();

      repeat (3) step();
      chk_outputs_zero("reset");
      i_rst_n = 1'b1;
      step();

      // First collision after reset: host wins, scan follows.
      txn(1'b1, 1'b1, 1'b0, 7'h01, 8'h00, 7'h30);
      chk("coll1_host_ack", h_ack, 3);
      chk("coll1_scan_ack", s_ack, 7);
      // After a host-only access the next collision goes to scan.
      txn(1'b1, 1'b0, 1'b0, 7'h05, 8'h00, 7'h00);
      txn(1'b1, 1'b1, 1'b0, 7'h02, 8'h00, 7'h31);
      chk("coll2_scan_ack", s_ack, 3);
      chk("coll2_host_ack", h_ack, 7);

      foreach (vecs[i]) begin
         if (!vecs[i].wr) begin
            mem[vecs[i].addr] = vecs[i].data;
            ref_mem[vecs[i].addr] = vecs[i].data;
         end
         txn(!vecs[i].scan, vecs[i].scan, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].addr);
         chk($sformatf("vec%0d_ack", i), vecs[i].scan ? s_ack : h_ack, vecs[i].ack_off);
         chk($sformatf("vec%0d_strobe", i), vecs[i].wr ? wr_at : rd_at, vecs[i].strobe_off);
         chk($sformatf("vec%0d_addr", i), strobe_addr, vecs[i].addr);
         if (vecs[i].wr) chk($sformatf("vec%0d_wdata", i), strobe_wdata, vecs[i].data);
         else chk($sformatf("vec%0d_rdata", i),
                  vecs[i].scan ? o_rac_wdg_scan_data : o_host_rdata, vecs[i].data);
      end

      // Scan request withdrawn right after grant still completes once.
      begin
         int n0;
         n0 = cyc;
         drive(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 7'h15);
         run(n0, 10, 1);
         model_check(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 7'h15);
         chk("drop_scan_ack", s_ack, 3);
      end

      // Write protection around the lock boundary.
      i_reg_lock = 1'b1;
      txn(1'b1, 1'b0, 1'b1, 7'h40, 8'h77, 7'h00);
`ifdef LV_RAC_WR_PROT_EN
      chk("lock40_wr_en", n_wr, 0);
      chk("lock40_err", {h_ack, err_at}, {32'sd2, 32'sd2});
`else
      chk("nolock40_wr_en", n_wr, 1);
      chk("nolock40_err", n_err, 0);
`endif
      txn(1'b1, 1'b0, 1'b1, 7'h3F, 8'h88, 7'h00);
      chk("lock3f_wr_en", n_wr, 1);
      chk("lock3f_err", n_err, 0);
      i_reg_lock = 1'b0;

      for (int r = 0; r < 40; r++) begin
         bit h, s;
         h = 1'($urandom_range(0, 1));
         s = h ? 1'($urandom_range(0, 1)) : 1'b1;
         txn(h, s, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 7'($urandom));
      end

      // Async reset in the middle of a host read (CAPT cycle).
      begin
         int n0;
         n0 = cyc;
         drive(1'b1, 1'b0, 1'b0, 7'h22, 8'h00, 7'h00);
         step();
         chk("mid_rd_en", o_reg_rd_en, 1'b1);
         step();
         i_rst_n = 1'b0;
         #1;
         chk_outputs_zero("midreset");
         step();
         i_rst_n = 1'b1;
         model_reset();
         n0 = cyc;
         run(n0, 10, 0);
         model_check(1'b1, 1'b0, 1'b0, 7'h22, 8'h00, 7'h00);
         chk("restart_rd_cyc", rd_at, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
